pad_mux_sequencer: RTL and testbench
====================================

Name: pad_mux_sequencer

Overview:
Parametrised pad-control block. It holds per-pad attribute registers and double-buffered (shadow/active) pad-mux selects behind a simple register bus. Mux changes take effect only on software commit. A sequencer parks every pad whose select changes, waits a settle time, switches, then releases, so no glitch reaches the pad ring. It sits between the peripheral bus and the pad ring, and replaces the fixed-count, immediate-update pad control.

Parameters:
NUM_PAD, 48, number of pads (1..256)
ATTR_W, 8, attribute bits per pad (1..32)
MUX_W, 4, mux select bits per pad (1..8)
SETTLE_CYCLES, 8, park/release settle time in clk_i cycles (1..255)
ATTR_RST, '0, reset value of every attribute register
MUX_RST, '0, reset value of every shadow and active mux select

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  bus request strobe
req_write_i  in  1  1=write, 0=read
req_addr_i  in  12  byte address (word-aligned; bits[1:0] ignored)
req_wdata_i  in  32  write data
rsp_valid_o  out  1  response strobe, exactly 1 cycle after each request
rsp_rdata_o  out  32  read data (0 on write or error)
rsp_error_o  out  1  bus error for this response
pad_attributes_o  out  NUM_PAD*ATTR_W  active attributes, packed pad-major
pad_muxes_o  out  NUM_PAD*MUX_W  active mux selects
pad_park_o  out  NUM_PAD  1 = pad forced to safe/idle state by ring
commit_done_o  out  1  one-cycle pulse when a commit completes

Behaviour:
- Register map:
  - ATTR[i] at 0x000+4i.
  - MUX_SHADOW[i] at 0x400+4i (i<NUM_PAD).
  - MUX_ACTIVE[i] at 0x800+4i, read-only.
  - CTRL at 0xC00: bit0 COMMIT, write-1 pulse, reads 0; bit1 LOCK, sticky set, clears only on reset.
  - STATUS at 0xC04, read-only: bit0 BUSY, bit1 LOCKED, bits[15:8] count of pads parked.
- Register fields are LSB-aligned. Unused bits read 0; writes to them are ignored.
- Bus errors (rsp_error_o=1, no state change):
  - unmapped address or index ≥ NUM_PAD;
  - write to MUX_ACTIVE or STATUS;
  - write to ATTR, MUX_SHADOW or COMMIT while LOCKED;
  - write to MUX_SHADOW or COMMIT while BUSY.
- Reads never error except on an unmapped address.
- ATTR writes update pad_attributes_o on the next cycle. They are allowed while BUSY.
- Commit FSM states: IDLE, PARK, SWITCH, RELEASE, DONE.
  - IDLE: on accepted COMMIT, latch chg[i] = (shadow[i] != active[i]).
    - If no pad changes, go straight to DONE.
    - Otherwise drive pad_park_o=chg the next cycle and go to PARK; the counter loads SETTLE_CYCLES.
  - PARK: decrement the counter. At 0 go to SWITCH.
  - SWITCH: one cycle. active[i] <= shadow[i] for chg pads; pad_muxes_o updates the following cycle. Counter reloads; go to RELEASE.
  - RELEASE: pad_park_o still asserted. At counter 0, deassert pad_park_o and go to DONE.
  - DONE: commit_done_o=1 for one cycle, then IDLE.
- BUSY = state != IDLE.
- Total latency from COMMIT request to commit_done_o is 2*SETTLE_CYCLES+4 cycles when any pad changes, and 2 cycles when none does.
- Unchanged pads never see pad_park_o or a mux change.
- Simultaneous events: the bus request is evaluated against state in the cycle it is presented. A COMMIT and a LOCK written in the same word both take effect: commit proceeds, lock applies afterwards.
- Reset, including mid-sequence:
  - FSM → IDLE; every shadow and active mux → MUX_RST; attributes → ATTR_RST.
  - pad_park_o, rsp_valid_o, rsp_error_o, rsp_rdata_o, commit_done_o all → 0.
  - LOCK cleared.
  - A request presented during reset gets no response.
- Back-to-back requests are allowed every cycle; responses pipeline one cycle behind.

Decomposition:
- Package pad_mux_sequencer_pkg holds:
  - address offsets (ATTR_BASE, MUX_SHADOW_BASE, MUX_ACTIVE_BASE, CTRL_ADDR, STATUS_ADDR);
  - CTRL/STATUS bit indices;
  - the FSM state enum seq_state_e.
- One natural sub-module, pad_mux_seq_fsm. It takes the commit strobe, the chg vector and SETTLE_CYCLES, and produces park, switch_en and done. Register file and bus decode stay in the top.

Test Plan:
- Reset, then read ATTR[0], MUX_SHADOW[5], STATUS → 0, 0, 0; all outputs 0; rsp_valid_o 1 cycle after each read.
- Write ATTR[3]=0xA5 → pad_attributes_o[3] = 0xA5 the next cycle. Write ATTR[48] (addr 0x0C0) → rsp_error_o=1, no state change.
- Write MUX_SHADOW[2]=0x3, MUX_SHADOW[7]=0x1, then COMMIT (SETTLE_CYCLES=8):
  - pad_park_o = bits 2 and 7 only;
  - pad_muxes_o[2] changes to 3 mid-park;
  - park clears;
  - commit_done_o pulses 20 cycles after the COMMIT request;
  - other pads are untouched.
- During BUSY: write MUX_SHADOW[2] → error, shadow unchanged; write ATTR[2]=0x11 → accepted, pad_attributes_o[2]=0x11 the next cycle; STATUS.BUSY reads 1.
- COMMIT with shadow == active → no park, commit_done_o pulses 2 cycles later.
- Set LOCK, then write ATTR[0] → error; reset mid-PARK → pad_park_o=0 and LOCKED=0 the next cycle, active mux = MUX_RST.

Source files
------------

// File: rtl/pad_mux_sequencer_pkg.sv
// Shared definitions for the pad mux sequencer.
// Register map offsets, CTRL/STATUS bit positions and the commit FSM states.
package pad_mux_sequencer_pkg;

    localparam logic [11:0] ATTR_BASE       = 12'h000;
    localparam logic [11:0] MUX_SHADOW_BASE = 12'h400;
    localparam logic [11:0] MUX_ACTIVE_BASE = 12'h800;
    localparam logic [11:0] CTRL_ADDR       = 12'hC00;
    localparam logic [11:0] STATUS_ADDR     = 12'hC04;

    localparam int CTRL_COMMIT_BIT   = 0;
    localparam int CTRL_LOCK_BIT     = 1;
    localparam int STATUS_BUSY_BIT   = 0;
    localparam int STATUS_LOCKED_BIT = 1;
    localparam int STATUS_PARKED_LSB = 8;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_PARK,
        SEQ_SWITCH,
        SEQ_RELEASE,
        SEQ_DONE
    } seq_state_e;

endpackage

// File: rtl/pad_mux_sequencer_if.sv
// Register bus between the peripheral fabric and the pad mux sequencer.
// One request per cycle, response one cycle later.
interface pad_mux_sequencer_if;
    import pad_mux_sequencer_pkg::*;

    logic        req_valid_i;
    logic        req_write_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

endinterface

// File: rtl/pad_mux_seq_fsm.sv
// Commit sequencer: park changing pads, settle, switch, settle, release.
// Park mask is captured at commit so only changing pads are ever parked.
module pad_mux_seq_fsm
    import pad_mux_sequencer_pkg::*;
#(
    parameter int NUM_PAD       = 48,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               commit_i,
    input  logic [NUM_PAD-1:0] chg_i,
    output logic [NUM_PAD-1:0] park_o,
    output logic               switch_en_o,
    output logic               done_o,
    output logic               busy_o
);

    seq_state_e         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [NUM_PAD-1:0] park_q, park_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        park_d  = park_q;
        done_d  = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (commit_i) begin
                    if (|chg_i) begin
                        park_d  = chg_i;
                        cnt_d   = 8'(SETTLE_CYCLES);
                        state_d = SEQ_PARK;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_PARK: begin
                if (cnt_q == 8'd0) state_d = SEQ_SWITCH;
                else               cnt_d   = cnt_q - 8'd1;
            end
            SEQ_SWITCH: begin
                // park + switch + release spans 2*SETTLE_CYCLES+2 cycles
                cnt_d   = 8'(SETTLE_CYCLES - 1);
                state_d = SEQ_RELEASE;
            end
            SEQ_RELEASE: begin
                if (cnt_q == 8'd0) begin
                    park_d  = '0;
                    state_d = SEQ_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SEQ_DONE: begin
                done_d  = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            park_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            park_q  <= park_d;
            done_q  <= done_d;
        end
    end

    assign park_o      = park_q;
    assign switch_en_o = (state_q == SEQ_SWITCH);
    assign done_o      = done_q;
    assign busy_o      = (state_q != SEQ_IDLE);

endmodule

// File: rtl/pad_mux_sequencer.sv
// Pad control block: attribute registers, shadow/active mux selects and
// register bus decode; mux changes are applied by the commit sequencer.
module pad_mux_sequencer
    import pad_mux_sequencer_pkg::*;
#(
    parameter int                NUM_PAD       = 48,
    parameter int                ATTR_W        = 8,
    parameter int                MUX_W         = 4,
    parameter int                SETTLE_CYCLES = 8,
    parameter logic [ATTR_W-1:0] ATTR_RST      = '0,
    parameter logic [MUX_W-1:0]  MUX_RST       = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    pad_mux_sequencer_if.slave        bus,
    output logic [NUM_PAD*ATTR_W-1:0] pad_attributes_o,
    output logic [NUM_PAD*MUX_W-1:0]  pad_muxes_o,
    output logic [NUM_PAD-1:0]        pad_park_o,
    output logic                      commit_done_o
);

    logic [ATTR_W-1:0] attr_q   [NUM_PAD];
    logic [ATTR_W-1:0] attr_d   [NUM_PAD];
    logic [MUX_W-1:0]  shadow_q [NUM_PAD];
    logic [MUX_W-1:0]  shadow_d [NUM_PAD];
    logic [MUX_W-1:0]  active_q [NUM_PAD];
    logic [MUX_W-1:0]  active_d [NUM_PAD];

    logic        lock_q, lock_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [NUM_PAD-1:0] chg;
    logic               commit, busy, switch_en;
    logic [8:0]         parked;

    logic [7:0] idx;
    logic       in_range, is_attr, is_shadow, is_active, is_ctrl, is_status;
    logic       mapped, commit_req, wr_err, err, accept, wr, rd;
    logic       unused_bits;

    assign idx       = bus.req_addr_i[9:2];
    assign in_range  = {1'b0, idx} < 9'(NUM_PAD);
    assign is_attr   = (bus.req_addr_i[11:10] == ATTR_BASE[11:10]) && in_range;
    assign is_shadow = (bus.req_addr_i[11:10] == MUX_SHADOW_BASE[11:10]) && in_range;
    assign is_active = (bus.req_addr_i[11:10] == MUX_ACTIVE_BASE[11:10]) && in_range;
    assign is_ctrl   = (bus.req_addr_i[11:2] == CTRL_ADDR[11:2]);
    assign is_status = (bus.req_addr_i[11:2] == STATUS_ADDR[11:2]);
    assign mapped    = is_attr | is_shadow | is_active | is_ctrl | is_status;

    assign commit_req = is_ctrl && bus.req_wdata_i[CTRL_COMMIT_BIT];

    // Lock and busy checks use the state seen in the request cycle
    assign wr_err = !mapped || is_active || is_status
                 || (lock_q && (is_attr || is_shadow || commit_req))
                 || (busy && (is_shadow || commit_req));
    assign err    = bus.req_write_i ? wr_err : !mapped;
    assign accept = bus.req_valid_i && !err;
    assign wr     = accept && bus.req_write_i;
    assign rd     = accept && !bus.req_write_i;
    assign commit = wr && commit_req;

    assign unused_bits = ^{bus.req_addr_i[1:0], bus.req_wdata_i, parked[8]};

    always_comb begin
        chg    = '0;
        parked = '0;
        for (int i = 0; i < NUM_PAD; i++) begin
            chg[i] = (shadow_q[i] != active_q[i]);
            parked = parked + 9'(pad_park_o[i]);
        end
    end

    always_comb begin
        attr_d      = attr_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        lock_d      = lock_q;
        rsp_valid_d = bus.req_valid_i;
        rsp_error_d = bus.req_valid_i && err;
        rsp_rdata_d = '0;
        for (int i = 0; i < NUM_PAD; i++) begin
            if (idx == 8'(i)) begin
                if (wr && is_attr)   attr_d[i]   = bus.req_wdata_i[ATTR_W-1:0];
                if (wr && is_shadow) shadow_d[i] = bus.req_wdata_i[MUX_W-1:0];
                if (rd && is_attr)   rsp_rdata_d = 32'(attr_q[i]);
                if (rd && is_shadow) rsp_rdata_d = 32'(shadow_q[i]);
                if (rd && is_active) rsp_rdata_d = 32'(active_q[i]);
            end
            if (switch_en && pad_park_o[i]) active_d[i] = shadow_q[i];
        end
        if (wr && is_ctrl && bus.req_wdata_i[CTRL_LOCK_BIT]) lock_d = 1'b1;
        if (rd && is_ctrl) rsp_rdata_d[CTRL_LOCK_BIT] = lock_q;
        if (rd && is_status) begin
            rsp_rdata_d[STATUS_BUSY_BIT]          = busy;
            rsp_rdata_d[STATUS_LOCKED_BIT]        = lock_q;
            rsp_rdata_d[STATUS_PARKED_LSB +: 8]   = parked[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            attr_q      <= '{default: ATTR_RST};
            shadow_q    <= '{default: MUX_RST};
            active_q    <= '{default: MUX_RST};
            lock_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            attr_q      <= attr_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            lock_q      <= lock_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    pad_mux_seq_fsm #(
        .NUM_PAD       (NUM_PAD),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .commit_i    (commit),
        .chg_i       (chg),
        .park_o      (pad_park_o),
        .switch_en_o (switch_en),
        .done_o      (commit_done_o),
        .busy_o      (busy)
    );

    always_comb begin
        pad_attributes_o = '0;
        pad_muxes_o      = '0;
        for (int i = 0; i < NUM_PAD; i++) begin
            pad_attributes_o[i*ATTR_W +: ATTR_W] = attr_q[i];
            pad_muxes_o[i*MUX_W +: MUX_W]        = active_q[i];
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_error_o = rsp_error_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_pad_mux_sequencer.sv
// Bench for pad_mux_sequencer: directed plan plus random bus traffic
// checked every cycle against a timing-window reference model.
module tb_pad_mux_sequencer;

    localparam int NP = 48;
    localparam int AW = 8;
    localparam int MW = 4;
    localparam int SC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NP*AW-1:0] pad_attributes;
    logic [NP*MW-1:0] pad_muxes;
    logic [NP-1:0]    pad_park;
    logic             commit_done;

    pad_mux_sequencer_if bus();

    pad_mux_sequencer #(
        .NUM_PAD       (NP),
        .ATTR_W        (AW),
        .MUX_W         (MW),
        .SETTLE_CYCLES (SC),
        .ATTR_RST      ('0),
        .MUX_RST       ('0)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .bus              (bus),
        .pad_attributes_o (pad_attributes),
        .pad_muxes_o      (pad_muxes),
        .pad_park_o       (pad_park),
        .commit_done_o    (commit_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: register contents plus the cycle a commit was taken
    logic [AW-1:0] m_attr   [NP];
    logic [MW-1:0] m_shadow [NP];
    logic [MW-1:0] m_active [NP];
    logic [NP-1:0] m_mask;
    bit m_lock, m_on, m_chg;
    int m_k0 = 0;
    int cyc = 0;

    function automatic int rel();
        return cyc - m_k0;
    endfunction

    function automatic bit m_busy();
        if (!m_on) return 1'b0;
        if (m_chg) return rel() >= 1 && rel() <= 2*SC+3;
        return rel() == 1;
    endfunction

    function automatic logic [NP-1:0] m_park();
        if (m_on && m_chg && rel() >= 1 && rel() <= 2*SC+2) return m_mask;
        return '0;
    endfunction

    function automatic bit m_done();
        return m_on && (rel() == (m_chg ? 2*SC+4 : 2));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NP; i++) begin
            m_attr[i] = '0;
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_lock = 1'b0;
        m_on = 1'b0;
        m_chg = 1'b0;
        m_mask = '0;
    endtask

    task automatic step(input bit r, input bit v, input bit w,
                        input logic [11:0] a, input logic [31:0] d);
        logic [11:0] off;
        int idx;
        bit is_attr, is_sh, is_act, is_ctrl, is_stat, mapped, cbit, err, e_v;
        logic [31:0] rdv;
        logic [NP*AW-1:0] ea;
        logic [NP*MW-1:0] em;
        rst = r;
        bus.req_valid_i = v;
        bus.req_write_i = w;
        bus.req_addr_i = a;
        bus.req_wdata_i = d;
        off = a & 12'hFFC;
        idx = 0;
        is_attr = 0; is_sh = 0; is_act = 0; is_ctrl = 0; is_stat = 0;
        if (off < 12'h400) begin
            idx = int'(off) / 4;
            is_attr = idx < NP;
        end else if (off < 12'h800) begin
            idx = (int'(off) - 'h400) / 4;
            is_sh = idx < NP;
        end else if (off < 12'hC00) begin
            idx = (int'(off) - 'h800) / 4;
            is_act = idx < NP;
        end else begin
            is_ctrl = (off == 12'hC00);
            is_stat = (off == 12'hC04);
        end
        mapped = is_attr || is_sh || is_act || is_ctrl || is_stat;
        cbit = is_ctrl && d[0];
        if (!mapped) err = 1;
        else if (w) err = is_act || is_stat
                       || (m_lock && (is_attr || is_sh || cbit))
                       || (m_busy() && (is_sh || cbit));
        else err = 0;
        rdv = '0;
        if (!w && mapped) begin
            if (is_attr) rdv = 32'(m_attr[idx]);
            if (is_sh)   rdv = 32'(m_shadow[idx]);
            if (is_act)  rdv = 32'(m_active[idx]);
            if (is_ctrl) rdv = {30'd0, m_lock, 1'b0};
            if (is_stat) rdv = {16'd0, 8'($countones(m_park())), 6'd0, m_lock, m_busy()};
        end
        e_v = v && !r;
        if (r) begin
            m_reset();
        end else if (v && w && !err) begin
            if (is_attr) m_attr[idx] = d[AW-1:0];
            if (is_sh) m_shadow[idx] = d[MW-1:0];
            if (cbit) begin
                for (int i = 0; i < NP; i++) m_mask[i] = (m_shadow[i] != m_active[i]);
                m_chg = |m_mask;
                m_on = 1'b1;
                m_k0 = cyc;
            end
            if (is_ctrl && d[1]) m_lock = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (m_on && m_chg && rel() == SC+3)
            for (int i = 0; i < NP; i++) m_active[i] = m_shadow[i];
        chk("rsp_valid", bus.rsp_valid_o, e_v);
        if (e_v) begin
            chk("rsp_error", bus.rsp_error_o, err);
            chk("rsp_rdata", bus.rsp_rdata_o, (err || w) ? 32'd0 : rdv);
        end
        for (int i = 0; i < NP; i++) begin
            ea[i*AW +: AW] = m_attr[i];
            em[i*MW +: MW] = m_active[i];
        end
        chk("pad_attr", pad_attributes, ea);
        chk("pad_mux", pad_muxes, em);
        chk("pad_park", pad_park, m_park());
        chk("commit_done", commit_done, m_done());
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        step(0, 1, 1, a, d);
    endtask

    task automatic rd(input logic [11:0] a);
        step(0, 1, 0, a, 32'd0);
    endtask

    task automatic idle();
        step(0, 0, 0, 12'd0, 32'd0);
    endtask

    task automatic wait_done(input int k, input int lat, input string tag);
        while (!commit_done && cyc - k < 100) idle();
        chk(tag, 32'(cyc - k), 32'(lat));
    endtask

    initial begin
        int k;
        logic [11:0] a;
        logic [31:0] d;
        bus.req_valid_i = 0;
        bus.req_write_i = 0;
        bus.req_addr_i = '0;
        bus.req_wdata_i = '0;
        m_reset();
        repeat (3) step(1, 1, 0, 12'h000, 32'd0);

        rd(12'h000);
        rd(12'h414);
        rd(12'hC04);
        chk("status_rst", bus.rsp_rdata_o, 32'd0);

        wr(12'h00C, 32'hA5);
        chk("attr3", pad_attributes[3*AW +: AW], 8'hA5);
        wr(12'h0C0, 32'h5A);
        chk("attr48_err", bus.rsp_error_o, 1'b1);

        wr(12'h408, 32'h3);
        wr(12'h41C, 32'h1);
        k = cyc;
        wr(12'hC00, 32'h1);
        chk("park_mask", pad_park, 48'h84);
        wr(12'h408, 32'h5);
        chk("busy_shadow_err", bus.rsp_error_o, 1'b1);
        wr(12'h008, 32'h11);
        chk("busy_attr2", pad_attributes[2*AW +: AW], 8'h11);
        rd(12'hC04);
        chk("busy_bit", bus.rsp_rdata_o[0], 1'b1);
        wait_done(k, 2*SC+4, "commit_lat");
        chk("mux2", pad_muxes[2*MW +: MW], 4'h3);
        chk("mux7", pad_muxes[7*MW +: MW], 4'h1);
        chk("park_clear", pad_park, '0);

        k = cyc;
        wr(12'hC00, 32'h1);
        chk("nochg_park", pad_park, '0);
        wait_done(k, 2, "nochg_lat");

        wr(12'h410, 32'h9);
        wr(12'hC00, 32'h3);
        wr(12'h000, 32'h77);
        chk("lock_attr_err", bus.rsp_error_o, 1'b1);
        idle();
        step(1, 0, 0, 12'd0, 32'd0);
        chk("rst_park", pad_park, '0);
        chk("rst_mux", pad_muxes, '0);
        rd(12'hC04);
        chk("rst_locked", bus.rsp_rdata_o[1], 1'b0);

        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a = 12'(4 * $urandom_range(0, NP+2));
                3, 4:    a = 12'h400 + 12'(4 * $urandom_range(0, NP+2));
                5:       a = 12'h800 + 12'(4 * $urandom_range(0, NP+2));
                6, 9:    a = 12'hC00;
                7:       a = 12'hC04;
                default: a = 12'($urandom);
            endcase
            a[1:0] = 2'($urandom);
            d = $urandom;
            if (a[11:2] == 10'h300) d[1] = ($urandom_range(0, 60) == 0);
            step($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
